// File: rtl/regfile_sb_pkg.sv
// Shared constants and types for the scoreboarded register file.
package regfile_sb_pkg;

    localparam int unsigned WIDTH_DEF = 64;
    localparam int unsigned DEPTH_DEF = 32;
    localparam int unsigned IDX_W_DEF = $clog2(DEPTH_DEF);

    typedef logic [IDX_W_DEF-1:0] reg_idx_t;

endpackage : regfile_sb_pkg

// File: rtl/regfile_sb_popcount.sv
// Parametrised population count of a bit vector.
module regfile_sb_popcount #(
    parameter int unsigned N       = 32,
    parameter int unsigned COUNT_W = 6
) (
    input  logic [N-1:0]       bits,
    output logic [COUNT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < N; i++) begin
            count = count + COUNT_W'(bits[i]);
        end
    end

endmodule : regfile_sb_popcount

// File: rtl/regfile_sb.sv
// Register file with a per-register pending (scoreboard) bit and reserve handshake.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2,
    output logic              ReadReady1,
    output logic              ReadReady2,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] ReserveRegister,
    input  logic              Reserve,
    output logic              ReserveAccept,
    output logic [ADDR_W:0]   PendingCount
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_nxt;
    logic [ADDR_W:0]  count_nxt;
    logic             wr_en;
    logic             rsv_en;

    assign wr_en = RegWrite && (WriteRegister != '0);

    // A write to the same register in this cycle frees it, so the reserve may proceed.
    assign ReserveAccept = Reserve && ((ReserveRegister == '0) || !pending[ReserveRegister] ||
                                       (RegWrite && (WriteRegister == ReserveRegister)));

    assign rsv_en = ReserveAccept && (ReserveRegister != '0);

    // Reserve wins over writeback clear so write+reserve leaves the register pending.
    always_comb begin
        pending_nxt = pending;
        if (wr_en) begin
            pending_nxt[WriteRegister] = 1'b0;
        end
        if (rsv_en) begin
            pending_nxt[ReserveRegister] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    regfile_sb_popcount #(
        .N       (DEPTH),
        .COUNT_W (ADDR_W + 1)
    ) u_popcount (
        .bits  (pending_nxt),
        .count (count_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[WriteRegister] <= WriteData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= '0;
            PendingCount <= '0;
        end else begin
            pending      <= pending_nxt;
            PendingCount <= count_nxt;
        end
    end

`ifdef REGFILE_SB_BYPASS_EN
    logic hit1;
    logic hit2;

    // rst_n gate keeps reads at zero while reset is held, even with a write presented.
    assign hit1 = rst_n && wr_en && (WriteRegister == ReadRegister1);
    assign hit2 = rst_n && wr_en && (WriteRegister == ReadRegister2);

    always_comb begin
        ReadData1  = (ReadRegister1 == '0) ? '0 : mem[ReadRegister1];
        ReadData2  = (ReadRegister2 == '0) ? '0 : mem[ReadRegister2];
        ReadReady1 = !pending[ReadRegister1];
        ReadReady2 = !pending[ReadRegister2];
        if (hit1) begin
            ReadData1  = WriteData;
            ReadReady1 = 1'b1;
        end
        if (hit2) begin
            ReadData2  = WriteData;
            ReadReady2 = 1'b1;
        end
    end
`else
    always_comb begin
        ReadData1  = (ReadRegister1 == '0) ? '0 : mem[ReadRegister1];
        ReadData2  = (ReadRegister2 == '0) ? '0 : mem[ReadRegister2];
        ReadReady1 = !pending[ReadRegister1];
        ReadReady2 = !pending[ReadRegister2];
    end
`endif

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (honours REGFILE_SB_BYPASS_EN).
module tb_regfile_sb;
    import regfile_sb_pkg::*;

    logic        clk;
    logic        rst_n;
    reg_idx_t    ReadRegister1, ReadRegister2, WriteRegister, ReserveRegister;
    logic [63:0] ReadData1, ReadData2, WriteData;
    logic        ReadReady1, ReadReady2, RegWrite, Reserve, ReserveAccept;
    logic [5:0]  PendingCount;

    int checks = 0;
    int errors = 0;

    regfile_sb dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ReadRegister1   (ReadRegister1),
        .ReadRegister2   (ReadRegister2),
        .ReadData1       (ReadData1),
        .ReadData2       (ReadData2),
        .ReadReady1      (ReadReady1),
        .ReadReady2      (ReadReady2),
        .WriteRegister   (WriteRegister),
        .WriteData       (WriteData),
        .RegWrite        (RegWrite),
        .ReserveRegister (ReserveRegister),
        .Reserve         (Reserve),
        .ReserveAccept   (ReserveAccept),
        .PendingCount    (PendingCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWrite = 1'b0;
        Reserve  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        WriteRegister = '0; WriteData = '0; RegWrite = 1'b0;
        ReserveRegister = 5'd5; Reserve = 1'b1;
        #3;
        check("rst_data1", ReadData1, 64'h0);
        check("rst_ready1", 64'(ReadReady1), 64'h1);
        check("rst_accept", 64'(ReserveAccept), 64'h1);
        check("rst_count", 64'(PendingCount), 64'h0);
        tick();
        tick();
        Reserve = 1'b0;
        rst_n = 1'b1;
        #1;

        // Every register reads zero and ready on both ports after reset
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = reg_idx_t'(i);
            ReadRegister2 = reg_idx_t'(31 - i);
            #1;
            check("init_data1", ReadData1, 64'h0);
            check("init_data2", ReadData2, 64'h0);
            check("init_ready1", 64'(ReadReady1), 64'h1);
            check("init_ready2", 64'(ReadReady2), 64'h1);
        end
        check("init_count", 64'(PendingCount), 64'h0);

        // Plain write, then read x5 and x0
        WriteRegister = 5'd5; WriteData = 64'hDEAD_BEEF_0000_0001; RegWrite = 1'b1;
        tick();
        idle();
        ReadRegister1 = 5'd5; ReadRegister2 = 5'd0;
        #1;
        check("x5_data", ReadData1, 64'hDEAD_BEEF_0000_0001);
        check("x0_data", ReadData2, 64'h0);

        // Writes and reserves to x0 leave no state
        WriteRegister = 5'd0; WriteData = 64'hFFFF; RegWrite = 1'b1;
        ReserveRegister = 5'd0; Reserve = 1'b1;
        #1;
        check("x0_accept", 64'(ReserveAccept), 64'h1);
        tick();
        idle();
        ReadRegister1 = 5'd0;
        #1;
        check("x0_after_wr", ReadData1, 64'h0);
        check("x0_ready", 64'(ReadReady1), 64'h1);
        check("x0_count", 64'(PendingCount), 64'h0);

        // Reserve x7, retry rejected, writeback clears
        ReserveRegister = 5'd7; Reserve = 1'b1;
        #1;
        check("x7_accept", 64'(ReserveAccept), 64'h1);
        tick();
        Reserve = 1'b0;
        ReadRegister1 = 5'd7;
        #1;
        check("x7_pending", 64'(ReadReady1), 64'h0);
        check("x7_count1", 64'(PendingCount), 64'h1);
        Reserve = 1'b1;
        #1;
        check("x7_reject", 64'(ReserveAccept), 64'h0);
        tick();
        Reserve = 1'b0;
        #1;
        check("x7_reject_count", 64'(PendingCount), 64'h1);
        WriteRegister = 5'd7; WriteData = 64'h42; RegWrite = 1'b1;
        tick();
        idle();
        #1;
        check("x7_ready", 64'(ReadReady1), 64'h1);
        check("x7_count0", 64'(PendingCount), 64'h0);
        check("x7_data", ReadData1, 64'h42);

        // Pending x9 with same-cycle write and reserve stays pending
        ReserveRegister = 5'd9; Reserve = 1'b1;
        tick();
        idle();
        WriteRegister = 5'd9; WriteData = 64'h10; RegWrite = 1'b1; Reserve = 1'b1;
        #1;
        check("x9_accept", 64'(ReserveAccept), 64'h1);
        tick();
        idle();
        ReadRegister1 = 5'd9;
        #1;
        check("x9_data", ReadData1, 64'h10);
        check("x9_pending", 64'(ReadReady1), 64'h0);
        check("x9_count", 64'(PendingCount), 64'h1);
        WriteRegister = 5'd9; WriteData = 64'h11; RegWrite = 1'b1;
        tick();
        idle();
        #1;
        check("x9_clear", 64'(PendingCount), 64'h0);

        // Write-to-read forwarding on a pending register
        WriteRegister = 5'd3; WriteData = 64'h11; RegWrite = 1'b1;
        ReserveRegister = 5'd3; Reserve = 1'b1;
        tick();
        idle();
        WriteRegister = 5'd3; WriteData = 64'h55; RegWrite = 1'b1;
        ReadRegister1 = 5'd3; ReadRegister2 = 5'd3;
        #1;
`ifdef REGFILE_SB_BYPASS_EN
        check("byp_data1", ReadData1, 64'h55);
        check("byp_data2", ReadData2, 64'h55);
        check("byp_ready1", 64'(ReadReady1), 64'h1);
`else
        check("byp_data1", ReadData1, 64'h11);
        check("byp_data2", ReadData2, 64'h11);
        check("byp_ready1", 64'(ReadReady1), 64'h0);
`endif
        tick();
        idle();
        #1;
        check("x3_data", ReadData1, 64'h55);
        check("x3_ready", 64'(ReadReady1), 64'h1);

        // Fill every reservation, then reset mid-cycle with a write presented
        for (int i = 1; i < 32; i++) begin
            ReserveRegister = reg_idx_t'(i); Reserve = 1'b1;
            #1;
            check("fill_accept", 64'(ReserveAccept), 64'h1);
            tick();
        end
        Reserve = 1'b0;
        ReadRegister1 = 5'd5; ReadRegister2 = 5'd31;
        #1;
        check("full_count", 64'(PendingCount), 64'd31);
        check("full_ready2", 64'(ReadReady2), 64'h0);
        check("full_x5", ReadData1, 64'hDEAD_BEEF_0000_0001);
        WriteRegister = 5'd4; WriteData = 64'hABCD; RegWrite = 1'b1;
        ReserveRegister = 5'd4; Reserve = 1'b1;
        #2;
        rst_n = 1'b0;
        ReadRegister2 = 5'd4;
        #1;
        check("mid_rst_count", 64'(PendingCount), 64'h0);
        check("mid_rst_data1", ReadData1, 64'h0);
        check("mid_rst_data2", ReadData2, 64'h0);
        check("mid_rst_ready1", 64'(ReadReady1), 64'h1);
        check("mid_rst_accept", 64'(ReserveAccept), 64'h1);
        tick();
        idle();
        rst_n = 1'b1;
        #1;
        check("post_rst_x4", ReadData2, 64'h0);
        check("post_rst_x5", ReadData1, 64'h0);
        check("post_rst_ready2", 64'(ReadReady2), 64'h1);
        check("post_rst_count", 64'(PendingCount), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile_sb
